sha2_block_engine: RTL and testbench

// Parametrised SHA-2 compression engine: SHA-256 (WORD_W=32) or SHA-512 (WORD_W=64), one round per cycle.

---
 rtl/sha2_pkg.sv | 82 ++++++++
 rtl/sha2_msg_sched.sv | 34 +++
 rtl/sha2_block_engine.sv | 161 ++++++++++++++++
 tb/tb_sha2_block_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants and round functions for the 32-bit and 64-bit engines.
// No latency: constants and pure combinational helpers only.
// No backpressure: carries no handshake logic.
package sha2_pkg;

    typedef enum logic [1:0] {LOAD, ROUND, FINAL, OUT} sha2_state_e;

    // SHA-512 round constants. The SHA-256 constants are the leading 32 bits of
    // the first 64 of these (same cube roots of the same primes, fewer bits).
    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // SHA-512 initial hash; the SHA-256 IV is the leading 32 bits of each word.
    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // All helpers work on zero-extended 64-bit containers; w selects 32 or 64.
    function automatic logic [63:0] k_word(input logic [6:0] t, input int w);
        return (w == 32) ? {32'h0, K512[t][63:32]} : K512[t];
    endfunction

    function automatic logic [63:0] iv_word(input logic [2:0] i, input int w);
        return (w == 32) ? {32'h0, IV512[i][63:32]} : IV512[i];
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] mask;
        mask = (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
        return ((x >> n) | (x << (w - n))) & mask;
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int w);
        return (w == 32) ? (rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w))
                         : (rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w));
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int w);
        return (w == 32) ? (rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w))
                         : (rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w));
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x, input int w);
        return (w == 32) ? (rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3))
                         : (rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7));
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x, input int w);
        return (w == 32) ? (rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10))
                         : (rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6));
    endfunction

    function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f, input logic [63:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// Message schedule: 16-word rolling window, loaded word by word then expanded one word per round.
// Latency: o_wt is the oldest window entry, registered; W_t valid in the cycle of round t.
// No backpressure: shifts whenever a load word or a round step is presented.
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              i_load_vld,
    input  logic [WORD_W-1:0] i_load_dat,
    input  logic              i_step,
    output logic [WORD_W-1:0] o_wt
);

    // r_win[0] is W_t for the current round, r_win[i] is W_{t+i}.
    logic [WORD_W-1:0] r_win [16];
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] w_in;

    assign w_new = WORD_W'(small_sigma1(64'(r_win[14]), WORD_W)) + r_win[9]
                 + WORD_W'(small_sigma0(64'(r_win[1]), WORD_W)) + r_win[0];
    assign w_in  = i_load_vld ? i_load_dat : w_new;
    assign o_wt  = r_win[0];

    // Shift the window down by one; new entry is either the incoming block word or W_{t+16}.
    always_ff @(posedge clk) begin
        if (i_load_vld || i_step) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_in;
        end
    end

endmodule

// File: rtl/sha2_block_engine.sv
// SHA-256/512 compression of one 16-word block, one round per cycle; multi-block chaining under SHA2_CHAIN_EN.
// Latency: 16th word accepted in cycle N -> out_valid in cycle N+ROUNDS+2.
// Backpressure: in_ready only in LOAD; digest held stable in OUT until out_ready.
module sha2_block_engine
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_first,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*WORD_W-1:0] digest,
    output logic                busy
);

    localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha2_block_engine: WORD_W must be 32 or 64");
    end

    sha2_state_e       r_state, w_next;
    logic [3:0]        r_wcnt;
    logic [6:0]        r_rcnt;
    logic [WORD_W-1:0] r_h [8];
    logic [WORD_W-1:0] r_v [8];   // working variables a..h
    logic              w_accept, w_blk_done, w_round_done;
    logic              w_from_iv, w_digest_due;
    logic [WORD_W-1:0] w_wt, w_t1, w_t2;

    assign w_accept     = in_valid && in_ready;
    assign w_blk_done   = w_accept && (r_wcnt == 4'd15);
    assign w_round_done = (r_rcnt == 7'(ROUNDS - 1));

`ifdef SHA2_CHAIN_EN
    logic r_first, r_last;

    // Framing flags travel with word 0 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept && r_wcnt == 4'd0) begin
            r_first <= in_first;
            r_last  <= in_last;
        end
    end

    assign w_from_iv    = r_first;
    assign w_digest_due = r_last;
`else
    // Single-block hashing: framing inputs have no effect.
    logic w_unused_framing;
    assign w_unused_framing = in_first ^ in_last;
    assign w_from_iv        = 1'b1;
    assign w_digest_due     = 1'b1;
`endif

    sha2_msg_sched #(.WORD_W(WORD_W)) u_sched (
        .clk        (clk),
        .i_load_vld (w_accept),
        .i_load_dat (in_data),
        .i_step     (r_state == ROUND),
        .o_wt       (w_wt)
    );

    assign w_t1 = r_v[7] + WORD_W'(big_sigma1(64'(r_v[4]), WORD_W))
                + WORD_W'(ch(64'(r_v[4]), 64'(r_v[5]), 64'(r_v[6])))
                + WORD_W'(k_word(r_rcnt, WORD_W)) + w_wt;
    assign w_t2 = WORD_W'(big_sigma0(64'(r_v[0]), WORD_W))
                + WORD_W'(maj(64'(r_v[0]), 64'(r_v[1]), 64'(r_v[2])));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_blk_done) w_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (w_round_done) w_next = FINAL;
            end
            FINAL: begin
                busy   = 1'b1;
                w_next = w_digest_due ? OUT : LOAD;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    // Counters, working variables and chaining state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= 4'd0;
            r_rcnt <= 7'd0;
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= WORD_W'(iv_word(3'(i), WORD_W));
                r_v[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: if (w_accept) begin
                    r_wcnt <= r_wcnt + 4'd1;
                    if (r_wcnt == 4'd15) begin
                        r_rcnt <= 7'd0;
                        for (int i = 0; i < 8; i++) begin
                            if (w_from_iv) begin
                                r_v[i] <= WORD_W'(iv_word(3'(i), WORD_W));
                                r_h[i] <= WORD_W'(iv_word(3'(i), WORD_W));
                            end else begin
                                r_v[i] <= r_h[i];
                            end
                        end
                    end
                end
                ROUND: begin
                    r_rcnt <= r_rcnt + 7'd1;
                    r_v[0] <= w_t1 + w_t2;
                    r_v[1] <= r_v[0];
                    r_v[2] <= r_v[1];
                    r_v[3] <= r_v[2];
                    r_v[4] <= r_v[3] + w_t1;
                    r_v[5] <= r_v[4];
                    r_v[6] <= r_v[5];
                    r_v[7] <= r_v[6];
                end
                FINAL: for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
                default: ;
            endcase
        end
    end

    // Digest is only driven while it is being offered.
    always_comb begin
        digest = '0;
        if (r_state == OUT)
            for (int i = 0; i < 8; i++) digest[(7-i)*WORD_W +: WORD_W] = r_h[i];
    end

endmodule

// File: tb/tb_sha2_block_engine.sv
module tb_sha2_block_engine;

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] D512    = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_first, in_last, out_valid, out_ready, busy;
    logic [31:0]  in_data;
    logic [255:0] digest;

    logic         v64, r64, ov64, ordy64, busy64, one64;
    logic [63:0]  d64;
    logic [511:0] dig64;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int cnt;
    logic [31:0] blk [16];

    sha2_block_engine #(.WORD_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .digest(digest), .busy(busy)
    );

    sha2_block_engine #(.WORD_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_data(d64),
        .in_first(one64), .in_last(one64), .out_valid(ov64), .out_ready(ordy64),
        .digest(dig64), .busy(busy64)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_empty();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = 32'h80000000;
    endtask

    // Drives the 16 words of blk; returns at the first falling edge after word 15 is taken.
    task automatic send32(input logic first, input logic last);
        int guard;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            in_first = first;
            in_last  = last;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    // Counts cycles from the round-0 cycle (1) until out_valid, bounded.
    task automatic wait_out32(output int l);
        l = 1;
        while (!out_valid && l < 300) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic ack32(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ovld_after_ack"}, 512'(out_valid), 512'(0));
        chk({tag, "_rdy_after_ack"}, 512'(in_ready), 512'(1));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_first = 0; in_last = 0; out_ready = 0;
        v64 = 0; d64 = 0; one64 = 1'b1; ordy64 = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_digest", 512'(digest), 512'(0));
        chk("rst_digest64", dig64, 512'(0));
        rst = 1'b0;

        // SHA-512 "abc"
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v64 = 1'b1;
            d64 = (i == 0) ? 64'h6162638000000000 : (i == 15) ? 64'h18 : 64'h0;
        end
        @(negedge clk);
        v64 = 1'b0;
        lat = 1;
        while (!ov64 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("sha512_latency", 512'(lat), 512'(82));
        chk("sha512_abc", dig64, D512);
        ordy64 = 1'b1;
        @(negedge clk);
        ordy64 = 1'b0;
        chk("sha512_ovld_after_ack", 512'(ov64), 512'(0));
        chk("sha512_rdy_after_ack", 512'(r64), 512'(1));

        // SHA-256 "abc"
        set_abc();
        send32(1'b1, 1'b1);
        chk("abc_busy_round", 512'(busy), 512'(1));
        chk("abc_rdy_round", 512'(in_ready), 512'(0));
        wait_out32(lat);
        chk("abc_latency", 512'(lat), 512'(66));
        chk("abc_digest", 512'(digest), 512'(D_ABC));
        chk("abc_busy_out", 512'(busy), 512'(0));
        ack32("abc");

        // SHA-256 empty message, sent back-to-back
        set_empty();
        send32(1'b1, 1'b1);
        wait_out32(lat);
        chk("empty_latency", 512'(lat), 512'(66));
        chk("empty_digest", 512'(digest), 512'(D_EMPTY));
        ack32("empty");

        // Sink stalls for 20 cycles while the source pokes in_valid
        set_abc();
        send32(1'b1, 1'b1);
        wait_out32(lat);
        for (int i = 0; i < 20; i++) begin
            chk("stall_digest", 512'(digest), 512'(D_ABC));
            chk("stall_in_ready", 512'(in_ready), 512'(0));
            chk("stall_out_valid", 512'(out_valid), 512'(1));
            in_valid = (i % 2 == 0);
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        ack32("stall");
        set_empty();
        send32(1'b1, 1'b1);
        wait_out32(lat);
        chk("after_stall_digest", 512'(digest), 512'(D_EMPTY));
        ack32("after_stall");

        // Reset during round 30 discards the block
        set_abc();
        send32(1'b1, 1'b1);
        repeat (30) @(negedge clk);
        chk("pre_rst_busy", 512'(busy), 512'(1));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        chk("midrst_busy", 512'(busy), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        send32(1'b1, 1'b1);
        wait_out32(lat);
        chk("resend_latency", 512'(lat), 512'(66));
        chk("resend_digest", 512'(digest), 512'(D_ABC));
        ack32("resend");

`ifdef SHA2_CHAIN_EN
        // Two-block message: no output after block 1, chained digest after block 2
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        send32(1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        chk("chain_blk1_no_output", 512'(cnt), 512'(0));
        chk("chain_blk1_ready", 512'(in_ready), 512'(1));
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[15] = 32'h000001c0;
        send32(1'b0, 1'b1);
        wait_out32(lat);
        chk("chain_latency", 512'(lat), 512'(66));
        chk("chain_digest", 512'(digest), 512'(D_TWO));
        ack32("chain");
        set_abc();
        send32(1'b1, 1'b1);
        wait_out32(lat);
        chk("chain_fresh_abc", 512'(digest), 512'(D_ABC));
        ack32("chain_fresh");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
